reset_sequencer: RTL
====================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter STAGE_DELAY, default 15: cycles between staged reset releases.
REQ-002 SHALL have parameter READY_TIMEOUT, default 65535: maximum cycles to wait for mem_ready.
REQ-003 SHALL have parameter DRAIN_TIMEOUT, default 1023: maximum cycles to wait for dma_idle.
REQ-004 SHALL have parameter NUM_REQ, default 2: number of soft-reset requesters, range 1..8.
REQ-005 clk  input  1  sole clock; all logic on posedge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 sys_reset  input  1  active-high system reset from the reset generator, synchronous to clk.
REQ-008 soft_req  input  NUM_REQ  level soft-reset requests; a requester holds its bit until it sees soft_ack.
REQ-009 mem_ready  input  1  SDRAM controller initialisation complete.
REQ-010 dma_idle  input  1  DMA engine has no transfer in progress.
REQ-011 mem_reset, dma_reset, bus_reset  output  1 each  active-high domain resets, driven directly from flops.
REQ-012 soft_ack  output  NUM_REQ  one-cycle one-hot completion pulse.
REQ-013 timeout_err  output  1  sticky flag set when a wait times out.
REQ-014 state_dbg  output  3  encoded current state.

Function
REQ-015 States: HOLD, MEM_WAIT, DMA_REL, RUN, DRAIN, SOFT; every state entry clears the cycle counter.
REQ-016 HOLD: all three resets = 1; when sys_reset = 0 is sampled, go to MEM_WAIT, with mem_reset = 0 on the next cycle.
REQ-017 MEM_WAIT: mem_reset = 0, dma_reset = bus_reset = 1; go to DMA_REL when mem_ready = 1.
REQ-018 MEM_WAIT timeout: when the counter reaches READY_TIMEOUT with mem_ready still 0, set timeout_err and go to DMA_REL.
REQ-019 DMA_REL: dma_reset = 0, bus_reset = 1; after STAGE_DELAY cycles, go to RUN.
REQ-020 RUN: all resets = 0; any nonzero soft_req triggers a grant to exactly one requester and a transition to DRAIN.
REQ-021 Arbitration SHALL be round-robin: search starts at the index after the last granted index, wraps modulo NUM_REQ, and the pointer is 0 after reset.
REQ-022 DRAIN: bus_reset = 1 from the first DRAIN cycle, dma_reset = 0; go to SOFT when dma_idle = 1.
REQ-023 DRAIN timeout: when the counter reaches DRAIN_TIMEOUT with dma_idle still 0, set timeout_err and go to SOFT.
REQ-024 SOFT: dma_reset = bus_reset = 1 and mem_reset stays 0, so SDRAM contents are preserved.
REQ-025 SOFT exit: after STAGE_DELAY cycles, pulse soft_ack[grant] for one cycle and go to DMA_REL in the same cycle.
REQ-026 soft_req is ignored in every state except RUN; its grant is latched at RUN exit, so later changes to soft_req do not alter it.
REQ-027 sys_reset = 1 in any state SHALL force HOLD on the next cycle, overriding all other events; an in-flight grant is dropped with no soft_ack.
REQ-028 mem_ready and dma_idle SHALL be sampled only in MEM_WAIT and DRAIN respectively.
REQ-029 Counter width SHALL be the ceiling log2 of the largest of STAGE_DELAY, READY_TIMEOUT and DRAIN_TIMEOUT; compares are equality, with no wrap.
REQ-030 timeout_err SHALL be cleared only by reset_n.

Reset
REQ-031 While reset_n = 0: state = HOLD, mem_reset = dma_reset = bus_reset = 1, soft_ack = 0, timeout_err = 0, counter = 0, round-robin pointer = 0, state_dbg = HOLD encoding.
REQ-032 reset_n assertion SHALL take effect asynchronously; release is synchronous to clk, with no action in the release cycle other than HOLD evaluation.

Structure
REQ-033 The state encoding, default parameter values and state_dbg codes SHALL live in package reset_seq_pkg.
REQ-034 Round-robin grant logic SHALL be sub-module rr_arbiter (request vector and pointer in, one-hot grant out); the FSM and counter stay in reset_sequencer.

Verification (STAGE_DELAY=3, READY_TIMEOUT=20, DRAIN_TIMEOUT=10, NUM_REQ=2)
REQ-035 Power-up: sys_reset falls at cycle 0, mem_ready rises at cycle 5 -> mem_reset falls at cycle 1, dma_reset falls at cycle 6, bus_reset falls at cycle 9, timeout_err = 0.
REQ-036 mem_ready held at 0 -> timeout_err = 1 after 20 MEM_WAIT cycles, then dma_reset falls and the sequence completes.
REQ-037 In RUN, soft_req = 2'b11 held -> first ack soft_ack = 2'b01, second ack 2'b10; mem_reset stays 0 throughout.
REQ-038 In RUN, soft_req[0] = 1 with dma_idle = 0 for 4 cycles -> bus_reset = 1 immediately, dma_reset rises after dma_idle, ack arrives 3 SOFT cycles later; with dma_idle stuck at 0, timeout_err = 1 after 10 cycles.
REQ-039 sys_reset pulsed during SOFT -> all resets = 1 on the next cycle, no soft_ack, full power-up sequence repeats.
REQ-040 reset_n asserted mid-DRAIN -> outputs reach their REQ-031 values without a clk edge.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared constants for the reset sequencer: state codes (also used as the
// state_dbg encoding), default parameter values and small helpers.
package reset_seq_pkg;

    // Default parameter values
    localparam int DEF_STAGE_DELAY   = 15;
    localparam int DEF_READY_TIMEOUT = 65535;
    localparam int DEF_DRAIN_TIMEOUT = 1023;
    localparam int DEF_NUM_REQ       = 2;

    // State codes, reported unchanged on state_dbg
    localparam logic [2:0] ST_HOLD     = 3'd0;
    localparam logic [2:0] ST_MEM_WAIT = 3'd1;
    localparam logic [2:0] ST_DMA_REL  = 3'd2;
    localparam logic [2:0] ST_RUN      = 3'd3;
    localparam logic [2:0] ST_DRAIN    = 3'd4;
    localparam logic [2:0] ST_SOFT     = 3'd5;

    // The three domain resets, grouped so they are produced together
    typedef struct packed {
        logic mem;
        logic dma;
        logic bus;
    } domain_rst_t;

    // Domain reset levels that belong to each state
    function automatic domain_rst_t domain_resets(input logic [2:0] st);
        domain_rst_t r;
        r.mem = 1'b1;
        r.dma = 1'b1;
        r.bus = 1'b1;
        case (st)
            ST_MEM_WAIT: begin r.mem = 1'b0; r.dma = 1'b1; r.bus = 1'b1; end
            ST_DMA_REL:  begin r.mem = 1'b0; r.dma = 1'b0; r.bus = 1'b1; end
            ST_RUN:      begin r.mem = 1'b0; r.dma = 1'b0; r.bus = 1'b0; end
            ST_DRAIN:    begin r.mem = 1'b0; r.dma = 1'b0; r.bus = 1'b1; end
            ST_SOFT:     begin r.mem = 1'b0; r.dma = 1'b1; r.bus = 1'b1; end
            default:     begin r.mem = 1'b1; r.dma = 1'b1; r.bus = 1'b1; end
        endcase
        return r;
    endfunction

    // Counter width: ceil(log2) of the longest wait, at least one bit.
    // The counter only ever has to reach (wait - 1), which always fits.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    // Width of a requester index / round-robin pointer
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after
// the pointer position, wrapping modulo NUM_REQ. Grant is one-hot, or zero
// when nothing is requested.
module rr_arbiter
    import reset_seq_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]             req,
    input  logic [ptr_width(NUM_REQ)-1:0]  ptr,
    output logic [NUM_REQ-1:0]             grant
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [NUM_REQ-1:0]   first_rot;
    logic [2*NUM_REQ-1:0] grant_dbl;

    // Rotate the request vector so the pointer position becomes bit 0
    assign req_dbl = {req, req};
    assign req_rot = req_dbl[ptr +: NUM_REQ];

    // Lowest set bit of the rotated vector is the winner
    assign first_rot = req_rot & (~req_rot + NUM_REQ'(1));

    // Rotate the winner back into the original requester numbering
    assign grant_dbl = {{NUM_REQ{1'b0}}, first_rot} << ptr;
    assign grant     = grant_dbl[NUM_REQ-1:0] | grant_dbl[2*NUM_REQ-1:NUM_REQ];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset sequencer: releases memory, DMA and bus domains in order after
// a system reset, and performs arbitrated soft resets of the DMA/bus domains
// while keeping SDRAM out of reset so its contents survive.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int STAGE_DELAY   = DEF_STAGE_DELAY,
    parameter int READY_TIMEOUT = DEF_READY_TIMEOUT,
    parameter int DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT,
    parameter int NUM_REQ       = DEF_NUM_REQ
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               sys_reset,
    input  logic [NUM_REQ-1:0] soft_req,
    input  logic               mem_ready,
    input  logic               dma_idle,
    output logic               mem_reset,
    output logic               dma_reset,
    output logic               bus_reset,
    output logic [NUM_REQ-1:0] soft_ack,
    output logic               timeout_err,
    output logic [2:0]         state_dbg
);

    localparam int CNT_W = cnt_width(STAGE_DELAY, READY_TIMEOUT, DRAIN_TIMEOUT);
    localparam int PTR_W = ptr_width(NUM_REQ);

    // Terminal counts: the counter starts at 0 on state entry, so a wait of
    // N cycles ends when the counter shows N-1.
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
    localparam logic [CNT_W-1:0] READY_LAST = CNT_W'(READY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

    logic [2:0]         state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [PTR_W-1:0]   ptr_reg, ptr_next;
    logic [NUM_REQ-1:0] grant_reg, grant_next;
    logic [NUM_REQ-1:0] ack_reg, ack_next;
    logic               err_reg, err_next;
    domain_rst_t        rst_reg, rst_next;

    logic [NUM_REQ-1:0] arb_grant;
    logic [PTR_W-1:0]   arb_ptr_next;
    logic [PTR_W-1:0]   ptr_terms [NUM_REQ];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req   (soft_req),
        .ptr   (ptr_reg),
        .grant (arb_grant)
    );

    // Pointer after a grant is the index just past the winner (mod NUM_REQ)
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ptr_terms
        assign ptr_terms[gi] = arb_grant[gi] ? PTR_W'((gi + 1) % NUM_REQ) : '0;
    end

    // Collapse the one-hot pointer candidates into the next pointer value
    always_comb begin
        arb_ptr_next = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            arb_ptr_next = arb_ptr_next | ptr_terms[i];
        end
    end

    // Next-state, counter, grant, acknowledge and timeout logic
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + CNT_W'(1);
        ptr_next   = ptr_reg;
        grant_next = grant_reg;
        ack_next   = '0;
        err_next   = err_reg;

        if (sys_reset) begin
            // System reset wins over everything; a pending grant is abandoned
            state_next = ST_HOLD;
            grant_next = '0;
        end else begin
            case (state_reg)
                ST_HOLD: begin
                    state_next = ST_MEM_WAIT;
                end
                ST_MEM_WAIT: begin
                    if (mem_ready) begin
                        state_next = ST_DMA_REL;
                    end else if (cnt_reg == READY_LAST) begin
                        err_next   = 1'b1;
                        state_next = ST_DMA_REL;
                    end
                end
                ST_DMA_REL: begin
                    if (cnt_reg == STAGE_LAST) begin
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (|soft_req) begin
                        state_next = ST_DRAIN;
                        grant_next = arb_grant;
                        ptr_next   = arb_ptr_next;
                    end
                end
                ST_DRAIN: begin
                    if (dma_idle) begin
                        state_next = ST_SOFT;
                    end else if (cnt_reg == DRAIN_LAST) begin
                        err_next   = 1'b1;
                        state_next = ST_SOFT;
                    end
                end
                ST_SOFT: begin
                    if (cnt_reg == STAGE_LAST) begin
                        ack_next   = grant_reg;
                        grant_next = '0;
                        state_next = ST_DMA_REL;
                    end
                end
                default: begin
                    state_next = ST_HOLD;
                end
            endcase
        end

        // Every state entry starts the count at zero; HOLD and RUN have no
        // timed exit, so the counter is parked there instead of wrapping.
        if ((state_next != state_reg) || (state_reg == ST_HOLD) || (state_reg == ST_RUN)) begin
            cnt_next = '0;
        end

        rst_next = domain_resets(state_next);
    end

    // State and output registers; reset_n forces the safe state immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_HOLD;
            cnt_reg   <= '0;
            ptr_reg   <= '0;
            grant_reg <= '0;
            ack_reg   <= '0;
            err_reg   <= 1'b0;
            rst_reg   <= '1;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ptr_reg   <= ptr_next;
            grant_reg <= grant_next;
            ack_reg   <= ack_next;
            err_reg   <= err_next;
            rst_reg   <= rst_next;
        end
    end

    assign mem_reset   = rst_reg.mem;
    assign dma_reset   = rst_reg.dma;
    assign bus_reset   = rst_reg.bus;
    assign soft_ack    = ack_reg;
    assign timeout_err = err_reg;
    assign state_dbg   = state_reg;

endmodule
